hmr_recovery_seq: RTL and testbench

HMR_RECOVERY_SEQ -- requirements
Module: hmr_recovery_seq

---
 rtl/hmr_pkg.sv | 15 +
 rtl/hmr_recovery_seq.sv | 157 +++++++++++++++
 tb/tb_hmr_recovery_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/hmr_pkg.sv
// Shared types for the HMR recovery sequencer.
// State encoding of the recovery FSM.
package hmr_pkg;

  typedef enum logic [2:0] {
    REC_IDLE,
    REC_HALT,
    REC_RF,
    REC_CSR,
    REC_PC,
    REC_RESUME,
    REC_DONE
  } rec_state_e;

endpackage

// File: rtl/hmr_recovery_seq.sv
// HMR recovery sequencer: halts the lockstepped cores, restores
// RF, CSRs and PC from the backup store, then releases them.
module hmr_recovery_seq
  import hmr_pkg::*;
#(
  parameter int unsigned NumCores  = 3,
  parameter int unsigned NumRegs   = 32,
  parameter int unsigned NumCsrs   = 4,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 recovery_request_i,
  output logic                 recovery_finished_o,
  output logic                 debug_req_o,
  input  logic [NumCores-1:0]  core_halted_i,
  output logic                 debug_resume_o,
  output logic                 backup_freeze_o,
  output logic                 backup_sel_o,
  output logic [$clog2((NumRegs > NumCsrs) ? NumRegs : NumCsrs)-1:0]
                               backup_raddr_o,
  input  logic [DataWidth-1:0] backup_rdata_i,
  input  logic [DataWidth-1:0] backup_pc_i,
  output logic                 rf_we_o,
  output logic [$clog2(NumRegs)-1:0] rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 csr_we_o,
  output logic [$clog2(NumCsrs)-1:0] csr_idx_o,
  output logic [DataWidth-1:0] csr_wdata_o,
  output logic                 pc_we_o,
  output logic [DataWidth-1:0] pc_wdata_o
);

  localparam int unsigned AW =
    $clog2((NumRegs > NumCsrs) ? NumRegs : NumCsrs);
  localparam int unsigned RW = $clog2(NumRegs);
  localparam int unsigned CW = $clog2(NumCsrs);
  localparam logic [AW-1:0] RfLast  = AW'(NumRegs - 1);
  localparam logic [AW-1:0] CsrLast = AW'(NumCsrs - 1);

  rec_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wv_q, wv_d;
  logic          wsel_q, wsel_d;
  logic [AW-1:0] wa_q, wa_d;
  logic          rd_en;
  logic          abortable;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= REC_IDLE;
      cnt_q   <= '0;
      wv_q    <= 1'b0;
      wsel_q  <= 1'b0;
      wa_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wv_q    <= wv_d;
      wsel_q  <= wsel_d;
      wa_q    <= wa_d;
    end
  end

  assign abortable = (state_q == REC_HALT) ||
                     (state_q == REC_RF)   ||
                     (state_q == REC_CSR)  ||
                     (state_q == REC_PC);

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    wv_d                = 1'b0;
    wsel_d              = wsel_q;
    wa_d                = wa_q;
    rd_en               = 1'b0;
    backup_sel_o        = 1'b0;
    debug_req_o         = 1'b0;
    debug_resume_o      = 1'b0;
    recovery_finished_o = 1'b0;
    pc_we_o             = 1'b0;
    unique case (state_q)
      REC_IDLE: begin
        cnt_d = '0;
        if (recovery_request_i) state_d = REC_HALT;
      end
      REC_HALT: begin
        debug_req_o = 1'b1;
        if (&core_halted_i) begin
          state_d = REC_RF;
          cnt_d   = AW'(1);
        end
      end
      REC_RF: begin
        debug_req_o = 1'b1;
        rd_en       = 1'b1;
        wv_d        = 1'b1;
        wsel_d      = 1'b0;
        wa_d        = cnt_q;
        if (cnt_q == RfLast) begin
          state_d = REC_CSR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      REC_CSR: begin
        debug_req_o  = 1'b1;
        rd_en        = 1'b1;
        backup_sel_o = 1'b1;
        wv_d         = 1'b1;
        wsel_d       = 1'b1;
        wa_d         = cnt_q;
        if (cnt_q == CsrLast) begin
          state_d = REC_PC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      REC_PC: begin
        debug_req_o = 1'b1;
        pc_we_o     = 1'b1;
        state_d     = REC_RESUME;
      end
      REC_RESUME: begin
        debug_resume_o = 1'b1;
        if (~|core_halted_i) state_d = REC_DONE;
      end
      REC_DONE: begin
        recovery_finished_o = 1'b1;
        state_d             = REC_IDLE;
      end
      default: state_d = REC_IDLE;
    endcase
    // Dropped request kills the sequence and the pending write.
    if (abortable && !recovery_request_i) begin
      state_d = REC_IDLE;
      cnt_d   = '0;
      wv_d    = 1'b0;
    end
  end

  assign backup_freeze_o = (state_q != REC_IDLE);
  assign backup_raddr_o  = rd_en ? cnt_q : '0;

  assign rf_we_o    = wv_q & ~wsel_q;
  assign rf_waddr_o = rf_we_o ? wa_q[RW-1:0] : '0;
  assign rf_wdata_o = rf_we_o ? backup_rdata_i : '0;

  assign csr_we_o    = wv_q & wsel_q;
  assign csr_idx_o   = csr_we_o ? wa_q[CW-1:0] : '0;
  assign csr_wdata_o = csr_we_o ? backup_rdata_i : '0;

  assign pc_wdata_o = pc_we_o ? backup_pc_i : '0;

endmodule

// File: tb/tb_hmr_recovery_seq.sv
// Randomized bench for hmr_recovery_seq against a
// timeline model of one recovery sequence.
module tb_hmr_recovery_seq;

  localparam int NCO = 3;
  localparam int NR  = 32;
  localparam int NC  = 4;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int RW  = 5;
  localparam int CW  = 2;
  localparam logic [31:0] RF_KEY  = 32'hA5A5A5A5;
  localparam logic [31:0] CSR_KEY = 32'h3C3C3C3C;

  logic           clk = 1'b0;
  logic           rst;
  logic           req;
  logic           fin;
  logic           dreq;
  logic [NCO-1:0] halted;
  logic           dres;
  logic           frz;
  logic           bsel;
  logic [AW-1:0]  braddr;
  logic [DW-1:0]  brdata;
  logic [DW-1:0]  bpc;
  logic           rfwe;
  logic [RW-1:0]  rfwa;
  logic [DW-1:0]  rfwd;
  logic           cswe;
  logic [CW-1:0]  csidx;
  logic [DW-1:0]  cswd;
  logic           pcwe;
  logic [DW-1:0]  pcwd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  hmr_recovery_seq #(
    .NumCores (NCO),
    .NumRegs  (NR),
    .NumCsrs  (NC),
    .DataWidth(DW)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .recovery_request_i (req),
    .recovery_finished_o(fin),
    .debug_req_o        (dreq),
    .core_halted_i      (halted),
    .debug_resume_o     (dres),
    .backup_freeze_o    (frz),
    .backup_sel_o       (bsel),
    .backup_raddr_o     (braddr),
    .backup_rdata_i     (brdata),
    .backup_pc_i        (bpc),
    .rf_we_o            (rfwe),
    .rf_waddr_o         (rfwa),
    .rf_wdata_o         (rfwd),
    .csr_we_o           (cswe),
    .csr_idx_o          (csidx),
    .csr_wdata_o        (cswd),
    .pc_we_o            (pcwe),
    .pc_wdata_o         (pcwd)
  );

  // Backup store: data appears one cycle after the address.
  logic [AW-1:0] sa = '0;
  logic          ss = 1'b0;
  logic [AW-1:0] la = '0;
  logic          ls = 1'b0;

  always @(negedge clk) begin
    sa = braddr;
    ss = bsel;
  end

  always @(posedge clk) begin
    la <= sa;
    ls <= ss;
  end

  assign brdata = ls ? (32'(la) ^ CSR_KEY) : (32'(la) ^ RF_KEY);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      check("idle_dreq", dreq, 0);
      check("idle_frz", frz, 0);
      check("idle_rfwe", rfwe, 0);
      check("idle_cswe", cswe, 0);
      check("idle_pcwe", pcwe, 0);
      check("idle_res", dres, 0);
      check("idle_fin", fin, 0);
      req    = 1'b0;
      halted = '0;
    end
  endtask

  // One recovery. Cycle 0 is IDLE with the request raised.
  // h: wait cycles in HALT, part: halted pattern while waiting
  // (<0 random), d: cycles cores stay halted in RESUME,
  // k: cycle of abort/reset (<0 none).
  task automatic run_rec(input int h, input int part, input int d,
                         input int k, input bit use_rst,
                         input bit keep);
    int S, R, E, last;
    logic [31:0] pc;
    bit idle, rfw, csw;
    S    = 2 + h;
    R    = S + 36;
    E    = R + d + 1;
    last = (k >= 0) ? k + 1 : E;
    pc   = $urandom;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      cyc++;
      idle = (c == 0) || (k >= 0 && c > k);
      rfw  = !idle && c >= S + 1 && c <= S + 31;
      csw  = !idle && c >= S + 32 && c <= S + 35;
      check("dreq", dreq, !idle && c <= S + 35);
      check("frz", frz, !idle && c <= E);
      check("rfwe", rfwe, rfw);
      if (rfw) begin
        check("rfwa", rfwa, c - S);
        check("rfwd", rfwd, (c - S) ^ RF_KEY);
      end
      check("cswe", cswe, csw);
      if (csw) begin
        check("csidx", csidx, c - S - 32);
        check("cswd", cswd, (c - S - 32) ^ CSR_KEY);
      end
      check("pcwe", pcwe, !idle && c == S + 35);
      if (!idle && c == S + 35) check("pcwd", pcwd, pc);
      check("res", dres, !idle && c >= R && c <= R + d);
      check("fin", fin, !idle && c == E);
      if (!idle && c >= S && c <= S + 30) begin
        check("rsel", bsel, 0);
        check("radr", braddr, c - S + 1);
      end
      if (!idle && c >= S + 31 && c <= S + 34) begin
        check("csel", bsel, 1);
        check("cadr", braddr, c - S - 31);
      end
      rst = use_rst && c == k;
      if (k >= 0 && c > k) req = 1'b0;
      else if (k >= 0 && !use_rst) req = (c < k);
      else if (c >= R && c < E) req = 1'($urandom_range(0, 1));
      else if (c == E) req = keep;
      else req = 1'b1;
      if ((k >= 0 && c > k) || c == 0) halted = '0;
      else if (c <= h)
        halted = (part < 0) ? 3'($urandom_range(0, 6)) : 3'(part);
      else if (c < R) halted = 3'b111;
      else if (c < R + d) halted = 3'($urandom_range(1, 7));
      else halted = '0;
      bpc = pc;
    end
  endtask

  initial begin
    int h, d, m, S, E, k;
    rst    = 1'b1;
    req    = 1'b0;
    halted = '0;
    bpc    = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dreq", dreq, 0);
    check("rst_res", dres, 0);
    check("rst_fin", fin, 0);
    check("rst_frz", frz, 0);
    check("rst_sel", bsel, 0);
    check("rst_radr", braddr, 0);
    check("rst_rfwe", rfwe, 0);
    check("rst_rfwa", rfwa, 0);
    check("rst_rfwd", rfwd, 0);
    check("rst_cswe", cswe, 0);
    check("rst_csidx", csidx, 0);
    check("rst_cswd", cswd, 0);
    check("rst_pcwe", pcwe, 0);
    check("rst_pcwd", pcwd, 0);
    rst = 1'b0;

    run_rec(0, 0, 0, -1, 1'b0, 1'b0);
    idle_cycles(2);
    run_rec(10, 3, 2, -1, 1'b0, 1'b0);
    idle_cycles(2);
    run_rec(2, -1, 1, 2 + 2 + 9, 1'b0, 1'b0);
    idle_cycles(2);
    run_rec(1, -1, 3, -1, 1'b0, 1'b0);
    idle_cycles(1);
    run_rec(0, 0, 1, 2 + 32, 1'b1, 1'b0);
    run_rec(0, 0, 0, -1, 1'b0, 1'b1);
    run_rec(1, -1, 1, -1, 1'b0, 1'b0);
    idle_cycles(2);

    for (int i = 0; i < 20; i++) begin
      h = $urandom_range(0, 4);
      d = $urandom_range(0, 3);
      m = $urandom_range(0, 3);
      S = 2 + h;
      E = S + 36 + d + 1;
      case (m)
        1: begin
          k = $urandom_range(1, S + 35);
          run_rec(h, -1, d, k, 1'b0, 1'b0);
        end
        2: begin
          k = $urandom_range(1, E);
          run_rec(h, -1, d, k, 1'b1, 1'b0);
        end
        3: run_rec(h, -1, d, -1, 1'b0, 1'b1);
        default: run_rec(h, -1, d, -1, 1'b0, 1'b0);
      endcase
      if (m != 3) idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
